mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the 6502 core and a DMA/loader master. Sits between `core_simple`, an external DMA port, and the synchronous-read block RAM in `top`. It muxes one request per cycle onto the RAM, stalls the core through a ready signal while DMA owns the RAM, and routes the one-cycle-late read data back to the owner. A burst limit guarantees the core forward progress.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (RAM depth = 2**ADDR_W)
- MAX_BURST, 4, max consecutive DMA grants before one forced core slot (1..15)
- WP_BASE, 16'h0300, first core address of the write-protected region (used only with MEM_ARB_WP_EN)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- c_en  in  1  core access valid this cycle
- c_addr  in  16  core address; low ADDR_W bits go to RAM
- c_wdata  in  8  core write data
- c_RW  in  1  1 = read, 0 = write (6502 convention)
- c_rdy  out  1  core access accepted this cycle; core holds c_* while low
- c_rdata  out  8  core read data, held stable between core reads
- d_req  in  1  DMA request
- d_addr  in  ADDR_W  DMA address
- d_wdata  in  8  DMA write data
- d_we  in  1  DMA write enable
- d_gnt  out  1  DMA request accepted this cycle
- d_rvalid  out  1  d_rdata valid (one cycle after a granted DMA read)
- d_rdata  out  8  DMA read data
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  8  RAM read data; registered, valid the cycle after the address
- wp_err  out  1  sticky write-protect violation flag

## Operation
- States: CORE (default) and DMA. A registered burst counter `bcnt` (4 bits) counts consecutive DMA grants.
- CORE: d_req=1 goes to DMA and grants d in the same cycle. Otherwise the core is granted (c_rdy=1, even when c_en=0).
- DMA: d_req=1 with bcnt<MAX_BURST grants DMA and increments bcnt.
  - If bcnt==MAX_BURST and c_en=1, the core is granted for exactly one cycle, bcnt clears, and the state stays DMA.
  - If bcnt==MAX_BURST and c_en=0, DMA continues and bcnt stays saturated.
  - d_req=0 returns to CORE and clears bcnt; the core is granted that same cycle.
- Grant mux (combinational): the winner drives ram_addr/ram_wdata. ram_we = c_en & ~c_RW for the core, d_we for DMA. No grant means ram_we=0.
- Read return: an owner tag is registered each cycle (CORE-read, DMA-read, none).
  - CORE-read tag: c_rdata <= ram_rdata, and c_rdata holds its value otherwise.
  - DMA-read tag: d_rvalid=1 and d_rdata=ram_rdata, combinational on the registered tag.
- Same-address write/read in consecutive cycles follows the RAM's native behaviour; no forwarding.

## Timing
- Reset values: state=CORE, bcnt=0, tag=none, c_rdy=1, d_gnt=0, d_rvalid=0, c_rdata=8'h00, wp_err=0, ram_we=0.
- Grant is zero-latency (combinational from d_req/c_en and registered state).
- Read latency is 1 cycle from grant to data on both ports.
- Reset mid-burst aborts the burst. The in-flight read tag clears, so no d_rvalid appears after reset.
- d_req and c_en asserted in the same cycle from CORE: DMA wins.

## Configuration
- MEM_ARB_WP_EN defined:
  - Core writes (c_RW=0, granted) with c_addr >= WP_BASE are suppressed: ram_we=0, but c_rdy is still asserted.
  - wp_err sets and stays set until i_rst.
  - DMA writes are never protected, so the loader can fill ROM.
- Not defined: the WP_BASE compare logic is absent and wp_err is tied 0.

## Structure
- Package `mem_pkg`: typedef `arb_state_t` {CORE, DMA}, typedef `rd_tag_t` {TAG_NONE, TAG_CORE, TAG_DMA}, and constant `RAM_DW = 8`.
- One sub-module, `arb_burst_ctr`: a saturating counter with clear, increment, and `at_max` output.

## Test plan
- Core only: c_en=1, reads 0x010–0x013 after DMA preload → c_rdy stays 1, and c_rdata returns the preload bytes one cycle later each.
- DMA burst: d_req held 10 cycles with c_en=1 and MAX_BURST=4 → d_gnt follows the pattern 4 on/1 off; c_rdy pulses once per 5 cycles; the core access on that pulse completes.
- Interleaved read: DMA reads 0x020 (holding 0xA5) while the core reads 0x021 (holding 0x5A) on the next cycle → d_rvalid=1 with 0xA5 only once; c_rdata=0x5A, unaffected by DMA data.
- Stall hold: DMA grants for 3 cycles while the core is stalled after reading 0x3C → c_rdata keeps 0x3C and no core write reaches the RAM.
- Reset mid-burst: i_rst asserted on the cycle after a DMA read grant → d_rvalid stays 0, state=CORE, c_rdy=1 on the next cycle.
- MEM_ARB_WP_EN: core writes 0xFF to 0x0310 → ram_we=0, wp_err=1 until reset; a DMA write to 0x0310 still lands.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the 6502/DMA single-port RAM arbiter.
package mem_pkg;

  localparam int RAM_DW = 8;
  localparam int BCNT_W = 4;

  typedef enum logic {
    CORE = 1'b0,
    DMA  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_DMA  = 2'd2
  } rd_tag_t;

  // Classify the access issued this cycle so its read data can be routed next cycle.
  function automatic rd_tag_t issue_tag(input logic grant_c, input logic c_en,
                                        input logic c_rw, input logic grant_d,
                                        input logic d_we);
    if (grant_d && !d_we)
      return TAG_DMA;
    else if (grant_c && c_en && c_rw)
      return TAG_CORE;
    else
      return TAG_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the 6502 core, the DMA master and the block RAM.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
);

  // core side
  logic              c_en;
  logic [15:0]       c_addr;
  logic [RAM_DW-1:0] c_wdata;
  logic              c_RW;
  logic              c_rdy;
  logic [RAM_DW-1:0] c_rdata;

  // DMA side
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [RAM_DW-1:0] d_wdata;
  logic              d_we;
  logic              d_gnt;
  logic              d_rvalid;
  logic [RAM_DW-1:0] d_rdata;

  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [RAM_DW-1:0] ram_wdata;
  logic              ram_we;
  logic [RAM_DW-1:0] ram_rdata;

  logic              wp_err;

  modport slave (
    input  c_en, c_addr, c_wdata, c_RW,
    output c_rdy, c_rdata,
    input  d_req, d_addr, d_wdata, d_we,
    output d_gnt, d_rvalid, d_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata,
    output wp_err
  );

  modport master (
    output c_en, c_addr, c_wdata, c_RW,
    input  c_rdy, c_rdata,
    output d_req, d_addr, d_wdata, d_we,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata,
    input  wp_err
  );

endinterface

// File: rtl/arb_burst_ctr.sv
// Saturating count of consecutive DMA grants; at_max tells the arbiter a core slot is owed.
module arb_burst_ctr
  import mem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  logic [BCNT_W-1:0] r_cnt;
  logic              w_at_max;

  assign w_at_max = (r_cnt == BCNT_W'(MAX));
  assign o_at_max = w_at_max;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && !w_at_max)
      r_cnt <= r_cnt + BCNT_W'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: core vs DMA with burst-limited DMA ownership.
// Optional write protection of the core's upper region is enabled by MEM_ARB_WP_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_BURST = 4,
  parameter logic [15:0] WP_BASE   = 16'h0300
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  rd_tag_t    r_tag;
  rd_tag_t    w_next_tag;

  logic [RAM_DW-1:0] r_c_rdata;

  logic w_grant_c;
  logic w_grant_d;
  logic w_bcnt_clr;
  logic w_bcnt_inc;
  logic w_at_max;
  logic w_core_wr;
  logic w_wp_hit;

  arb_burst_ctr #(
    .MAX (MAX_BURST)
  ) u_burst_ctr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_bcnt_clr),
    .i_inc    (w_bcnt_inc),
    .o_at_max (w_at_max)
  );

  // NOTE: every combinational output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    w_grant_c    = 1'b0;
    w_grant_d    = 1'b0;
    w_bcnt_clr   = 1'b0;
    w_bcnt_inc   = 1'b0;

    if (i_rst) begin
      // Hold the bus in its idle, core-owned shape while reset is asserted.
      w_grant_c = 1'b1;
    end else begin
      unique case (r_state)
        CORE: begin
          if (bus.d_req) begin
            w_next_state = DMA;
            w_grant_d    = 1'b1;
            w_bcnt_inc   = 1'b1;
          end else begin
            w_grant_c = 1'b1;
          end
        end
        DMA: begin
          if (!bus.d_req) begin
            w_next_state = CORE;
            w_bcnt_clr   = 1'b1;
            w_grant_c    = 1'b1;
          end else if (!w_at_max) begin
            w_grant_d  = 1'b1;
            w_bcnt_inc = 1'b1;
          end else if (bus.c_en) begin
            // Forced core slot: the core gets one access, DMA keeps ownership.
            w_grant_c  = 1'b1;
            w_bcnt_clr = 1'b1;
          end else begin
            w_grant_d = 1'b1;
          end
        end
        default: w_next_state = CORE;
      endcase
    end
  end

  assign w_core_wr = w_grant_c & bus.c_en & ~bus.c_RW & ~i_rst;

`ifdef MEM_ARB_WP_EN
  logic r_wp_err;

  assign w_wp_hit = w_core_wr & (bus.c_addr >= WP_BASE);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_wp_err <= 1'b0;
    else if (w_wp_hit)
      r_wp_err <= 1'b1;
  end

  assign bus.wp_err = r_wp_err;
`else
  logic w_unused_hi;

  // Upper core address bits only matter for the protection compare.
  assign w_unused_hi = ^bus.c_addr[15:ADDR_W];
  assign w_wp_hit    = 1'b0;
  assign bus.wp_err  = 1'b0;
`endif

  always_comb begin
    bus.ram_addr  = bus.c_addr[ADDR_W-1:0];
    bus.ram_wdata = bus.c_wdata;
    bus.ram_we    = w_core_wr & ~w_wp_hit;
    if (w_grant_d) begin
      bus.ram_addr  = bus.d_addr;
      bus.ram_wdata = bus.d_wdata;
      bus.ram_we    = bus.d_we;
    end
  end

  assign w_next_tag = issue_tag(w_grant_c, bus.c_en, bus.c_RW, w_grant_d, bus.d_we);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= CORE;
      r_tag     <= TAG_NONE;
      r_c_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_tag   <= w_next_tag;
      if (r_tag == TAG_CORE)
        r_c_rdata <= bus.ram_rdata;
    end
  end

  assign bus.c_rdy    = w_grant_c;
  assign bus.d_gnt    = w_grant_d;
  assign bus.d_rvalid = (r_tag == TAG_DMA) & ~i_rst;
  assign bus.d_rdata  = bus.ram_rdata;

  // Fresh read data passes straight through on the return cycle, then the copy holds it.
  assign bus.c_rdata  = ((r_tag == TAG_CORE) && !i_rst) ? bus.ram_rdata : r_c_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a read-first block RAM model.
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
`ifdef MEM_ARB_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (4),
    .WP_BASE   (16'h0300)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [7:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          c_en;
    bit          c_rw;
    logic [15:0] c_addr;
    logic [7:0]  c_wd;
    bit          d_req;
    bit          d_we;
    logic [9:0]  d_addr;
    logic [7:0]  d_wd;
    bit          e_rdy;
    bit          e_gnt;
    bit          e_we;
    logic [9:0]  e_addr;
    bit          e_rv;
    logic [7:0]  e_drd;
    logic [7:0]  e_crd;
    bit          e_wp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rs, input bit ce, input bit crw, input logic [15:0] ca,
                              input logic [7:0] cwd, input bit dr, input bit dwe,
                              input logic [9:0] da, input logic [7:0] dwd,
                              input bit erdy, input bit egnt, input bit ewe, input logic [9:0] eaddr,
                              input bit erv, input logic [7:0] edrd, input logic [7:0] ecrd,
                              input bit ewp);
    vec_t v;
    v.rst = rs; v.c_en = ce; v.c_rw = crw; v.c_addr = ca; v.c_wd = cwd;
    v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wd = dwd;
    v.e_rdy = erdy; v.e_gnt = egnt; v.e_we = ewe; v.e_addr = eaddr;
    v.e_rv = erv; v.e_drd = edrd; v.e_crd = ecrd; v.e_wp = ewp;
    return v;
  endfunction

  task automatic drive(input bit rs, input bit ce, input bit crw, input logic [15:0] ca,
                       input logic [7:0] cwd, input bit dr, input bit dwe,
                       input logic [9:0] da, input logic [7:0] dwd);
    rst         = rs;
    bus.c_en    = ce;
    bus.c_RW    = crw;
    bus.c_addr  = ca;
    bus.c_wdata = cwd;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] pre_a [7];
  logic [7:0] pre_d [7];

  initial begin
    pre_a = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h020, 10'h021, 10'h030};
    pre_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'h3C};

    // reset
    vecs.push_back(mk(1,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h00,0));
    vecs.push_back(mk(1,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h00,0));
    // DMA preload, core idle: saturated burst keeps DMA granted
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0,0,1,16'h0,8'h0, 1,1,pre_a[k],pre_d[k], 0,1,1,pre_a[k], 0,8'h0,8'h00,0));
    // core-only reads 0x010..0x013
    vecs.push_back(mk(0,1,1,16'h010,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h010, 0,8'h0,8'h00,0));
    vecs.push_back(mk(0,1,1,16'h011,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h011, 0,8'h0,8'h11,0));
    vecs.push_back(mk(0,1,1,16'h012,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h012, 0,8'h0,8'h22,0));
    vecs.push_back(mk(0,1,1,16'h013,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h013, 0,8'h0,8'h33,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h44,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h44,0));
    // interleaved: DMA reads 0x020 (wins tie), core reads 0x021 next cycle
    vecs.push_back(mk(0,1,1,16'h021,8'h0, 1,0,10'h020,8'h0, 0,1,0,10'h020, 0,8'h0,8'h44,0));
    vecs.push_back(mk(0,1,1,16'h021,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h021, 1,8'hA5,8'h44,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h5A,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h5A,0));
    // stall hold: core reads 0x3C, then is stalled on a write during 3 DMA reads
    vecs.push_back(mk(0,1,1,16'h030,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h030, 0,8'h0,8'h5A,0));
    vecs.push_back(mk(0,1,0,16'h011,8'hEE, 1,0,10'h010,8'h0, 0,1,0,10'h010, 0,8'h0,8'h3C,0));
    vecs.push_back(mk(0,1,0,16'h011,8'hEE, 1,0,10'h011,8'h0, 0,1,0,10'h011, 1,8'h11,8'h3C,0));
    vecs.push_back(mk(0,1,0,16'h011,8'hEE, 1,0,10'h012,8'h0, 0,1,0,10'h012, 1,8'h22,8'h3C,0));
    vecs.push_back(mk(0,1,0,16'h011,8'hEE, 0,0,10'h0,8'h0, 1,0,1,10'h011, 1,8'h33,8'h3C,0));
    vecs.push_back(mk(0,1,1,16'h011,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h011, 0,8'h0,8'h3C,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'hEE,0));
    // DMA burst of 10 with core waiting: pattern 4 on / 1 off
    for (int k = 0; k < 10; k++) begin
      bit g;
      bit rv;
      g  = (k != 4) && (k != 9);
      rv = (k != 0) && (k != 5);
      vecs.push_back(mk(0,1,1,16'h012,8'h0, 1,0,10'h013,8'h0, !g,g,0, g ? 10'h013 : 10'h012,
                        rv,8'h44, (k <= 4) ? 8'hEE : 8'h33, 0));
    end
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h33,0));
    // core write into protected region, then DMA write there, then read back
    vecs.push_back(mk(0,1,0,16'h0310,8'hFF, 0,0,10'h0,8'h0, 1,0,!WP,10'h310, 0,8'h0,8'h33,0));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 1,1,10'h310,8'h77, 0,1,1,10'h310, 0,8'h0,8'h33,WP));
    vecs.push_back(mk(0,1,1,16'h0310,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h310, 0,8'h0,8'h33,WP));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h77,WP));
    // reset on the cycle after a DMA read grant
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 1,0,10'h010,8'h0, 0,1,0,10'h010, 0,8'h0,8'h77,WP));
    vecs.push_back(mk(1,0,1,16'h0,8'h0, 1,0,10'h010,8'h0, 1,0,0,10'h0, 0,8'h0,8'h77,WP));
    vecs.push_back(mk(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0, 1,0,0,10'h0, 0,8'h0,8'h00,0));

    drive(1,0,1,16'h0,8'h0, 0,0,10'h0,8'h0);
    #1;
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.c_en, v.c_rw, v.c_addr, v.c_wd, v.d_req, v.d_we, v.d_addr, v.d_wd);
      @(negedge clk);
      check($sformatf("v%0d c_rdy", i),    32'(bus.c_rdy),    32'(v.e_rdy));
      check($sformatf("v%0d d_gnt", i),    32'(bus.d_gnt),    32'(v.e_gnt));
      check($sformatf("v%0d ram_we", i),   32'(bus.ram_we),   32'(v.e_we));
      check($sformatf("v%0d ram_addr", i), 32'(bus.ram_addr), 32'(v.e_addr));
      check($sformatf("v%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(v.e_rv));
      check($sformatf("v%0d c_rdata", i),  32'(bus.c_rdata),  32'(v.e_crd));
      check($sformatf("v%0d wp_err", i),   32'(bus.wp_err),   32'(v.e_wp));
      if (v.e_rv)
        check($sformatf("v%0d d_rdata", i), 32'(bus.d_rdata), 32'(v.e_drd));
      if (v.e_we)
        check($sformatf("v%0d ram_wdata", i), 32'(bus.ram_wdata),
              32'(v.e_gnt ? v.d_wd : v.c_wd));
      next_cycle();
    end

    // Saturated DMA run with the core idle, then the core asks and gets one slot.
    for (int k = 0; k < 6; k++) begin
      drive(0,0,1,16'h0,8'h0, 1,0,10'h010,8'h0);
      @(negedge clk);
      check($sformatf("sat%0d d_gnt", k), 32'(bus.d_gnt), 32'd1);
      next_cycle();
    end
    drive(0,1,1,16'h012,8'h0, 1,0,10'h010,8'h0);
    @(negedge clk);
    check("slot c_rdy", 32'(bus.c_rdy), 32'd1);
    check("slot d_gnt", 32'(bus.d_gnt), 32'd0);
    check("slot ram_addr", 32'(bus.ram_addr), 32'h012);
    next_cycle();
    drive(0,0,1,16'h0,8'h0, 1,0,10'h010,8'h0);
    @(negedge clk);
    check("after slot d_gnt", 32'(bus.d_gnt), 32'd1);
    check("after slot c_rdata", 32'(bus.c_rdata), 32'h33);
    check("after slot d_rvalid", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    drive(0,0,1,16'h0,8'h0, 0,0,10'h0,8'h0);
    @(negedge clk);
    check("tail d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("tail d_rdata", 32'(bus.d_rdata), 32'h11);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
